// File: rtl/timer_share_arbiter_if.sv
// Handshake bundle between timeout requesters and the shared countdown timer.
// The master side posts requests; the slave side (the arbiter) returns grant/done/status.
interface timer_share_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDXW  = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_delay;
  logic [NREQ-1:0]       abort;
  logic                  enable;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [IDXW-1:0]       owner;

  modport master (
    output req, req_delay, abort, enable,
    input  grant, done, busy, count, owner
  );

  modport slave (
    input  req, req_delay, abort, enable,
    output grant, done, busy, count, owner
  );
endinterface

// File: rtl/timer_share_arbiter.sv
// Round-robin owner of a single countdown timer: grant, load delay, count to zero,
// pulse done to the owner. All outputs come straight from registers.
module timer_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDXW  = 2
) (
  input logic                  clk,
  input logic                  resetn,
  timer_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   last_q, last_d;

  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [IDXW-1:0]   winner;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  winner_delay;

  // Rotating search starting just after the last served requester.
  always_comb begin
    eligible = bus.req & ~bus.abort;
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDXW'((32'(last_q) + k) % NREQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    winner_delay = bus.req_delay[32'(winner) * WIDTH +: WIDTH];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = done_q;
    busy_d  = busy_q;
    count_d = count_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StCount;
          owner_d = winner;
          grant_d = NREQ'(1) << winner;
          count_d = winner_delay;
          busy_d  = 1'b1;
        end
      end
      StCount: begin
        // Abort beats expiry: a cancelled owner never sees done.
        if (bus.abort[owner_q]) begin
          state_d = StIdle;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (bus.enable) begin
          if (count_q == '0) begin
            state_d = StDone;
            done_d  = NREQ'(1) << owner_q;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      owner_q <= '0;
      last_q  <= IDXW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Bench for timer_share_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked every cycle against a transaction-level reference model.
module tb_timer_share_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDXW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   abort;
  logic              enable;
  logic [WIDTH-1:0]  dly [NREQ];

  timer_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  assign bus.req    = req;
  assign bus.abort  = abort;
  assign bus.enable = enable;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dly
    assign bus.req_delay[gi*WIDTH +: WIDTH] = dly[gi];
  end

  timer_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who holds the timer (-1 = nobody), whether this is the expiry cycle.
  int               m_active = -1;
  bit               m_fired  = 1'b0;
  logic [WIDTH-1:0] m_count  = '0;
  int               m_owner  = 0;
  int               m_last   = NREQ - 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!resetn) begin
      m_active = -1; m_fired = 1'b0; m_count = '0; m_owner = 0; m_last = NREQ - 1;
    end else if (m_fired) begin
      m_fired = 1'b0; m_last = m_owner; m_active = -1;
    end else if (m_active >= 0) begin
      if (abort[m_active]) m_active = -1;
      else if (enable) begin
        if (m_count == 0) m_fired = 1'b1;
        else m_count = m_count - 1;
      end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (req[i] && !abort[i]) begin
          m_active = i; m_owner = i; m_count = dly[i];
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [NREQ-1:0] eg, ed;
    eg = (m_active >= 0) ? (NREQ'(1) << m_active) : '0;
    ed = m_fired ? (NREQ'(1) << m_owner) : '0;
    chk("m_grant", bus.grant, eg);
    chk("m_done",  bus.done,  ed);
    chk("m_busy",  bus.busy,  (m_active >= 0));
    chk("m_count", bus.count, m_count);
    chk("m_owner", bus.owner, m_owner);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_dly(input logic [WIDTH-1:0] v);
    for (int i = 0; i < NREQ; i++) dly[i] = v;
  endtask

  task automatic do_reset();
    req = '0; abort = '0; enable = 1'b1; resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  typedef struct {
    bit              rstn;
    logic [NREQ-1:0] rq;
    logic [31:0]     dl;
    logic [NREQ-1:0] ab;
    bit              en;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    bit              b;
    logic [31:0]     c;
    int              o;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int              ord [$];
    int              exp_ord [3];
    logic [NREQ-1:0] prev_g;
    int              n;

    // rstn req dly abort en | grant done busy count owner
    tbl[0]  = '{0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0};
    tbl[1]  = '{1, 4'b0001, 5, 4'b0000, 1, 4'b0001, 4'b0000, 1, 5, 0};
    tbl[2]  = '{1, 4'b0000, 5, 4'b0000, 1, 4'b0001, 4'b0000, 1, 4, 0};
    tbl[3]  = '{1, 4'b0000, 5, 4'b0000, 1, 4'b0001, 4'b0000, 1, 3, 0};
    tbl[4]  = '{1, 4'b0000, 5, 4'b0000, 1, 4'b0001, 4'b0000, 1, 2, 0};
    tbl[5]  = '{1, 4'b0000, 5, 4'b0000, 1, 4'b0001, 4'b0000, 1, 1, 0};
    tbl[6]  = '{1, 4'b0000, 5, 4'b0000, 1, 4'b0001, 4'b0000, 1, 0, 0};
    tbl[7]  = '{1, 4'b0000, 5, 4'b0000, 1, 4'b0001, 4'b0001, 1, 0, 0};
    tbl[8]  = '{1, 4'b0000, 5, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0};
    tbl[9]  = '{1, 4'b0010, 0, 4'b0000, 1, 4'b0010, 4'b0000, 1, 0, 1};
    tbl[10] = '{1, 4'b0000, 0, 4'b0000, 1, 4'b0010, 4'b0010, 1, 0, 1};
    tbl[11] = '{1, 4'b0000, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 1};
    tbl[12] = '{1, 4'b0001, 1, 4'b0000, 1, 4'b0001, 4'b0000, 1, 1, 0};
    tbl[13] = '{1, 4'b0000, 1, 4'b0000, 1, 4'b0001, 4'b0000, 1, 0, 0};
    tbl[14] = '{1, 4'b0000, 1, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0, 0};
    tbl[15] = '{1, 4'b0000, 1, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0};

    req = '0; abort = '0; enable = 1'b1; resetn = 1'b0; set_dly('0);

    for (int r = 0; r < 16; r++) begin
      resetn = tbl[r].rstn; req = tbl[r].rq; abort = tbl[r].ab; enable = tbl[r].en;
      set_dly(tbl[r].dl);
      tick();
      chk($sformatf("row%0d_grant", r), bus.grant, tbl[r].g);
      chk($sformatf("row%0d_done", r),  bus.done,  tbl[r].d);
      chk($sformatf("row%0d_busy", r),  bus.busy,  tbl[r].b);
      chk($sformatf("row%0d_count", r), bus.count, tbl[r].c);
      chk($sformatf("row%0d_owner", r), bus.owner, tbl[r].o);
    end

    // Two contenders, req0 held: service order 0, 2, 0.
    do_reset();
    set_dly(3);
    req = 4'b0101;
    prev_g = '0;
    for (int c = 0; c < 80 && ord.size() < 3; c++) begin
      tick();
      if (bus.grant != '0 && prev_g == '0) ord.push_back(int'(bus.grant));
      prev_g = bus.grant;
    end
    req = '0;
    exp_ord = '{1, 4, 1};
    chk("t2_grant_count", ord.size(), 3);
    for (int i = 0; i < ord.size() && i < 3; i++) chk($sformatf("t2_order%0d", i), ord[i], exp_ord[i]);
    for (int c = 0; c < 20 && bus.busy; c++) tick();

    // Abort owner at count 40; pending req3 is granted on the next edge.
    do_reset();
    set_dly(100);
    req = 4'b1010;
    tick();
    chk("t4_grant1", bus.grant, 4'b0010);
    for (int c = 0; c < 200 && bus.count != 40; c++) tick();
    chk("t4_reach40", bus.count, 40);
    abort = 4'b0010;
    tick();
    chk("t4_abort_grant", bus.grant, 4'b0000);
    chk("t4_abort_count", bus.count, 40);
    chk("t4_abort_done",  bus.done,  4'b0000);
    tick();
    chk("t4_next_grant", bus.grant, 4'b1000);
    chk("t4_next_owner", bus.owner, 3);
    abort = '0; req = '0;
    for (int c = 0; c < 200 && bus.busy; c++) tick();

    // Ten frozen cycles push done out from 9 to 19 cycles after grant.
    do_reset();
    set_dly(8);
    req = 4'b0001;
    tick();
    req = '0;
    n = 0;
    while (n < 40) begin
      enable = !(n >= 2 && n < 12);
      tick();
      n++;
      if (bus.done[0]) break;
    end
    chk("t5_latency", n, 19);
    enable = 1'b1;
    tick();

    // Reset mid-count, then priority restarts at requester 0.
    set_dly(50);
    req = 4'b0001;
    tick();
    tick(); tick(); tick();
    resetn = 1'b0; req = '0;
    tick();
    chk("t6_rst_grant", bus.grant, 4'b0000);
    chk("t6_rst_busy",  bus.busy,  1'b0);
    chk("t6_rst_count", bus.count, 0);
    chk("t6_rst_done",  bus.done,  4'b0000);
    resetn = 1'b1;
    req = 4'b1001;
    tick();
    chk("t6_first_grant", bus.grant, 4'b0001);
    req = '0; abort = 4'b0001;
    tick();
    abort = '0;

    // Full-range delay loads without wrap.
    dly[2] = '1;
    req = 4'b0100;
    tick();
    req = '0;
    chk("t7_max_load", bus.count, 32'hFFFF_FFFF);
    tick();
    chk("t7_max_dec", bus.count, 32'hFFFF_FFFE);
    abort = 4'b0100;
    tick();
    abort = '0;

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 9) == 0) dly[i] = WIDTH'($urandom_range(0, 12));
      end
      abort  = ($urandom_range(0, 19) == 0) ? NREQ'($urandom_range(1, 15)) : '0;
      enable = ($urandom_range(0, 4) != 0);
      resetn = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
